serial_stream_host: RTL and testbench

- Host-side endpoint of the 1-bit serial sample link used by the FIR filter top level.
- Transmit side: takes parallel DATA_WIDTH-bit samples and serializes them, MSB first, onto the link that feeds the filter's serial input.
- Receive side: collects the filter's serial output bits back into parallel words.
- Instantiated in the board wrapper and the system testbench, so both directions of the link honour the same valid/ready bit protocol.

---
 rtl/serial_stream_host.sv | 118 +++++++++++
 tb/tb_serial_stream_host.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_stream_host.sv
// Host endpoint of the 1-bit serial sample link: MSB-first serializer on the
// transmit side, deserializer with a one-word output register on the receive side.
module serial_stream_host #(
  parameter int LENGTH      = 24,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [LENGTH-1:0]      iv_tx_data,
  input  logic                   i_tx_valid,
  output logic                   o_tx_ready,
  output logic                   o_ser_dout,
  output logic                   o_ser_dout_valid,
  input  logic                   i_ser_ready,
  input  logic                   i_ser_din,
  input  logic                   i_ser_din_valid,
  output logic                   o_ser_ready,
  output logic [LENGTH-1:0]      ov_rx_data,
  output logic                   o_rx_valid,
  input  logic                   i_rx_ready,
  output logic [COUNT_WIDTH-1:0] ov_tx_count,
  output logic [COUNT_WIDTH-1:0] ov_rx_count
);

  localparam int BW = (LENGTH > 2) ? $clog2(LENGTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(LENGTH - 1);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  tx_state_t              r_tx_state;
  logic [LENGTH-1:0]      r_tx_shreg;
  logic [BW-1:0]          r_tx_bit_cnt;
  logic [COUNT_WIDTH-1:0] r_tx_count;

  logic [LENGTH-1:0]      r_rx_shreg;
  logic [BW-1:0]          r_rx_bit_cnt;
  logic [LENGTH-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic [COUNT_WIDTH-1:0] r_rx_count;

  logic w_rx_last;
  logic w_rx_xfer;
  logic w_rx_load;

  // TX outputs decode straight from the state flop; i_ser_ready never reaches them.
  assign o_tx_ready       = i_en & (r_tx_state == TX_IDLE);
  assign o_ser_dout_valid = i_en & (r_tx_state == TX_SHIFT);
  assign o_ser_dout       = r_tx_shreg[LENGTH-1];
  assign ov_tx_count      = r_tx_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state   <= TX_IDLE;
      r_tx_shreg   <= '0;
      r_tx_bit_cnt <= '0;
      r_tx_count   <= '0;
    end else if (i_en) begin
      case (r_tx_state)
        TX_IDLE: begin
          if (i_tx_valid) begin
            r_tx_shreg   <= iv_tx_data;
            r_tx_bit_cnt <= '0;
            r_tx_state   <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (i_ser_ready) begin
            r_tx_shreg   <= {r_tx_shreg[LENGTH-2:0], 1'b0};
            r_tx_bit_cnt <= r_tx_bit_cnt + 1'b1;
            if (r_tx_bit_cnt == LAST) begin
              r_tx_state <= TX_IDLE;
              r_tx_count <= r_tx_count + 1'b1;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // Only the word-completing bit is held off while the output register is full.
  assign w_rx_last   = (r_rx_bit_cnt == LAST);
  assign o_ser_ready = i_en & ~(w_rx_last & r_rx_valid & ~i_rx_ready);
  assign w_rx_xfer   = i_ser_din_valid & o_ser_ready;
  assign w_rx_load   = w_rx_xfer & w_rx_last;

  assign ov_rx_data  = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign ov_rx_count = r_rx_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_shreg   <= '0;
      r_rx_bit_cnt <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_count   <= '0;
    end else if (i_en) begin
      if (w_rx_xfer) begin
        r_rx_shreg <= {r_rx_shreg[LENGTH-2:0], i_ser_din};
        if (w_rx_last) begin
          r_rx_data    <= {r_rx_shreg[LENGTH-2:0], i_ser_din};
          r_rx_bit_cnt <= '0;
          r_rx_count   <= r_rx_count + 1'b1;
        end else begin
          r_rx_bit_cnt <= r_rx_bit_cnt + 1'b1;
        end
      end
      if (w_rx_load) begin
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_stream_host.sv
// Directed bench for serial_stream_host: tx framing, stalls, loopback, rx
// back-pressure, enable hold, mid-word reset and counter wrap (narrow instance).
module tb_serial_stream_host;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [23:0] tx_data;
  logic        tx_valid, ser_ready_drv, ser_din_drv, din_valid_drv, rx_ready, loop;

  logic        w_ser_ready, w_ser_din, w_din_valid;
  logic        tx_ready, ser_dout, ser_dout_valid, ser_ready, rx_valid;
  logic [23:0] rx_data;
  logic [15:0] tx_count, rx_count;

  logic        w2_tx_ready, w2_ser_dout, w2_ser_dout_valid, w2_ser_ready, w2_rx_valid;
  logic [23:0] w2_rx_data;
  logic [2:0]  w2_tx_count, w2_rx_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign w_ser_ready = loop ? ser_ready      : ser_ready_drv;
  assign w_ser_din   = loop ? ser_dout       : ser_din_drv;
  assign w_din_valid = loop ? ser_dout_valid : din_valid_drv;

  serial_stream_host #(.LENGTH(24), .COUNT_WIDTH(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .iv_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_ser_dout(ser_dout), .o_ser_dout_valid(ser_dout_valid), .i_ser_ready(w_ser_ready),
    .i_ser_din(w_ser_din), .i_ser_din_valid(w_din_valid), .o_ser_ready(ser_ready),
    .ov_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .ov_tx_count(tx_count), .ov_rx_count(rx_count)
  );

  serial_stream_host #(.LENGTH(24), .COUNT_WIDTH(3)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .iv_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(w2_tx_ready),
    .o_ser_dout(w2_ser_dout), .o_ser_dout_valid(w2_ser_dout_valid), .i_ser_ready(w_ser_ready),
    .i_ser_din(w_ser_din), .i_ser_din_valid(w_din_valid), .o_ser_ready(w2_ser_ready),
    .ov_rx_data(w2_rx_data), .o_rx_valid(w2_rx_valid), .i_rx_ready(rx_ready),
    .ov_tx_count(w2_tx_count), .ov_rx_count(w2_rx_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [23:0] d);
    for (int k = 0; k < 100 && !tx_ready; k++) tick();
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL send_wait tx_ready=%b want 1", tx_ready);
    else passes++;
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; tx_data = '0; tx_valid = 1'b0; ser_ready_drv = 1'b1;
    ser_din_drv = 1'b0; din_valid_drv = 1'b0; rx_ready = 1'b0; loop = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if ({tx_ready, ser_dout_valid, ser_dout} !== 3'b100)
      $display("FAIL reset_tx {rdy,vld,dout}=%b want 100", {tx_ready, ser_dout_valid, ser_dout}); else passes++;
    checks++; if ({tx_count, rx_count} !== 32'h0)
      $display("FAIL reset_counts tx=%h rx=%h want 0", tx_count, rx_count); else passes++;
    checks++; if ({rx_valid, rx_data} !== 25'h0)
      $display("FAIL reset_rx valid=%b data=%h want 0", rx_valid, rx_data); else passes++;
    checks++; if (ser_ready !== 1'b1)
      $display("FAIL reset_ser_ready got %b want 1", ser_ready); else passes++;
  endtask

  task automatic test_tx_basic();
    logic [23:0] w;
    w = 24'hA5C3F0;
    send_word(w);
    checks++; if (tx_ready !== 1'b0) $display("FAIL tx_busy tx_ready=%b want 0", tx_ready); else passes++;
    for (int i = 0; i < 24; i++) begin
      checks++; if ({ser_dout_valid, ser_dout} !== {1'b1, w[23-i]})
        $display("FAIL tx_bit%0d {vld,dout}=%b want 1%b", i, {ser_dout_valid, ser_dout}, w[23-i]); else passes++;
      tick();
    end
    checks++; if ({tx_ready, ser_dout_valid} !== 2'b10)
      $display("FAIL tx_done {rdy,vld}=%b want 10", {tx_ready, ser_dout_valid}); else passes++;
    checks++; if (tx_count !== 16'd1) $display("FAIL tx_count1 got %0d want 1", tx_count); else passes++;
  endtask

  task automatic test_tx_stall();
    logic [23:0] w;
    int idx, cyc;
    w = 24'h3C5A96;
    send_word(w);
    idx = 0; cyc = 0;
    while (idx < 24 && cyc < 100) begin
      ser_ready_drv = (cyc % 2 == 0);
      checks++; if ({ser_dout_valid, ser_dout} !== {1'b1, w[23-idx]})
        $display("FAIL stall_c%0d {vld,dout}=%b want 1%b", cyc, {ser_dout_valid, ser_dout}, w[23-idx]); else passes++;
      tick();
      if (ser_ready_drv) idx++;
      cyc++;
    end
    ser_ready_drv = 1'b1;
    checks++; if (cyc !== 47) $display("FAIL stall_cycles got %0d want 47", cyc); else passes++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL stall_idle tx_ready=%b want 1", tx_ready); else passes++;
    checks++; if (tx_count !== 16'd2) $display("FAIL tx_count2 got %0d want 2", tx_count); else passes++;
  endtask

  task automatic test_loopback();
    loop = 1'b1; rx_ready = 1'b1;
    send_word(24'h000001);
    repeat (24) tick();
    checks++; if ({rx_valid, rx_data} !== {1'b1, 24'h000001})
      $display("FAIL loop_w1 valid=%b data=%h want 1 000001", rx_valid, rx_data); else passes++;
    checks++; if (rx_count !== 16'd1) $display("FAIL loop_cnt1 got %0d want 1", rx_count); else passes++;
    send_word(24'hFFFFFE);
    repeat (24) tick();
    checks++; if ({rx_valid, rx_data} !== {1'b1, 24'hFFFFFE})
      $display("FAIL loop_w2 valid=%b data=%h want 1 fffffe", rx_valid, rx_data); else passes++;
    checks++; if ({rx_count, tx_count} !== {16'd2, 16'd4})
      $display("FAIL loop_counts rx=%0d tx=%0d want 2 4", rx_count, tx_count); else passes++;
    loop = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [23:0] w3, w4;
    w3 = 24'h5A3C01; w4 = 24'hC3A5E7;
    rx_ready = 1'b1; din_valid_drv = 1'b0;
    tick();
    checks++; if (rx_valid !== 1'b0) $display("FAIL bp_drain rx_valid=%b want 0", rx_valid); else passes++;
    rx_ready = 1'b0; din_valid_drv = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ser_din_drv = w3[23-i];
      tick();
    end
    checks++; if ({rx_valid, rx_data, rx_count} !== {1'b1, w3, 16'd3})
      $display("FAIL bp_w3 valid=%b data=%h cnt=%0d want 1 %h 3", rx_valid, rx_data, rx_count, w3); else passes++;
    for (int i = 0; i < 23; i++) begin
      ser_din_drv = w4[23-i];
      checks++; if (ser_ready !== 1'b1) $display("FAIL bp_bit%0d ser_ready=%b want 1", i, ser_ready); else passes++;
      tick();
    end
    ser_din_drv = w4[0];
    checks++; if (ser_ready !== 1'b0) $display("FAIL bp_last ser_ready=%b want 0", ser_ready); else passes++;
    repeat (2) tick();
    checks++; if ({ser_ready, rx_data, rx_count} !== {1'b0, w3, 16'd3})
      $display("FAIL bp_hold rdy=%b data=%h cnt=%0d want 0 %h 3", ser_ready, rx_data, rx_count, w3); else passes++;
    rx_ready = 1'b1;
    #1;
    checks++; if (ser_ready !== 1'b1) $display("FAIL bp_release ser_ready=%b want 1", ser_ready); else passes++;
    tick();
    checks++; if ({rx_valid, rx_data, rx_count} !== {1'b1, w4, 16'd4})
      $display("FAIL bp_w4 valid=%b data=%h cnt=%0d want 1 %h 4", rx_valid, rx_data, rx_count, w4); else passes++;
    din_valid_drv = 1'b0;
    tick();
    checks++; if (rx_valid !== 1'b0) $display("FAIL bp_consume rx_valid=%b want 0", rx_valid); else passes++;
  endtask

  task automatic test_enable();
    logic [23:0] w;
    w = 24'h96E14B;
    loop = 1'b1; rx_ready = 1'b1;
    send_word(w);
    for (int i = 0; i < 10; i++) begin
      checks++; if ({ser_dout_valid, ser_dout} !== {1'b1, w[23-i]})
        $display("FAIL en_pre%0d {vld,dout}=%b want 1%b", i, {ser_dout_valid, ser_dout}, w[23-i]); else passes++;
      tick();
    end
    en = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({ser_dout_valid, ser_ready, tx_ready} !== 3'b000)
        $display("FAIL en_off%0d {vld,srdy,trdy}=%b want 000", i, {ser_dout_valid, ser_ready, tx_ready}); else passes++;
      tick();
    end
    en = 1'b1;
    #1;
    for (int i = 10; i < 24; i++) begin
      checks++; if ({ser_dout_valid, ser_dout} !== {1'b1, w[23-i]})
        $display("FAIL en_post%0d {vld,dout}=%b want 1%b", i, {ser_dout_valid, ser_dout}, w[23-i]); else passes++;
      tick();
    end
    checks++; if ({rx_valid, rx_data} !== {1'b1, w})
      $display("FAIL en_rx valid=%b data=%h want 1 %h", rx_valid, rx_data, w); else passes++;
    checks++; if ({tx_count, rx_count} !== {16'd5, 16'd5})
      $display("FAIL en_counts tx=%0d rx=%0d want 5 5", tx_count, rx_count); else passes++;
    loop = 1'b0;
  endtask

  task automatic test_reset_mid();
    ser_ready_drv = 1'b1; din_valid_drv = 1'b0;
    send_word(24'hFEDCBA);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    checks++; if ({ser_dout_valid, tx_ready} !== 2'b01)
      $display("FAIL rstmid_tx {vld,rdy}=%b want 01", {ser_dout_valid, tx_ready}); else passes++;
    checks++; if ({tx_count, rx_count} !== 32'h0)
      $display("FAIL rstmid_counts tx=%0d rx=%0d want 0 0", tx_count, rx_count); else passes++;
    rst = 1'b0;
    tick();
    checks++; if ({ser_dout_valid, tx_ready, tx_count} !== {2'b01, 16'd0})
      $display("FAIL rstmid_after {vld,rdy}=%b cnt=%0d want 01 0", {ser_dout_valid, tx_ready}, tx_count); else passes++;
  endtask

  task automatic test_wrap();
    logic [23:0] w;
    rx_ready = 1'b1; din_valid_drv = 1'b1;
    for (int n = 0; n < 9; n++) begin
      w = {8'(n), 16'hB00D} ^ 24'h5A0000;
      for (int i = 0; i < 24; i++) begin
        ser_din_drv = w[23-i];
        tick();
      end
      checks++; if ({w2_rx_count, rx_count} !== {3'(n + 1), 16'(n + 1)})
        $display("FAIL wrap_cnt%0d narrow=%0d wide=%0d want %0d %0d", n, w2_rx_count, rx_count, 3'(n + 1), n + 1); else passes++;
      checks++; if (rx_data !== w) $display("FAIL wrap_data%0d got %h want %h", n, rx_data, w); else passes++;
    end
    din_valid_drv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_stall();
    test_loopback();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
